// File: rtl/clkdiv_pkg.sv
// rtl/clkdiv_pkg.sv - shared width/default constants and divisor type for clkdiv_multi
package clkdiv_pkg;

    localparam int CLKDIV_CW      = 25;
    localparam int DEFAULT_HALF_C = 24999999;

    typedef logic [CLKDIV_CW-1:0] half_t;

    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clkdiv_multi_if.sv
// rtl/clkdiv_multi_if.sv - divisor write handshake bundle for clkdiv_multi
interface clkdiv_multi_if
    import clkdiv_pkg::*;
#(
    parameter int NCH = 4,
    parameter int CW  = CLKDIV_CW
);
    localparam int CHW = ch_width(NCH);

    logic           cfg_valid;
    logic [CHW-1:0] cfg_ch;
    logic [CW-1:0]  cfg_half;
    logic           cfg_ready;

    modport master (output cfg_valid, cfg_ch, cfg_half, input cfg_ready);
    modport slave  (input cfg_valid, cfg_ch, cfg_half, output cfg_ready);

endinterface

// File: rtl/clkdiv_ch.sv
// rtl/clkdiv_ch.sv - one divider channel; optional sync restart under CLKDIV_SYNC_EN
module clkdiv_ch #(
    parameter int            CW           = 25,
    parameter logic [CW-1:0] DEFAULT_HALF = '1
) (
    input  logic          clk,
    input  logic          clear,
`ifdef CLKDIV_SYNC_EN
    input  logic          sync,
`endif
    input  logic          en,
    input  logic          wr,
    input  logic [CW-1:0] wr_half,
    output logic          clk_div,
    output logic          tick,
    output logic          pend_valid
);
    logic [CW-1:0] cnt;
    logic [CW-1:0] half_act;
    logic [CW-1:0] half_pend;
    logic          restart;
    logic          toggle;

`ifdef CLKDIV_SYNC_EN
    assign restart = sync;
`else
    assign restart = 1'b0;
`endif

    assign toggle = (cnt >= half_act);

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            cnt        <= '0;
            half_act   <= DEFAULT_HALF;
            half_pend  <= '0;
            pend_valid <= 1'b0;
            clk_div    <= 1'b0;
            tick       <= 1'b0;
        end else begin
            // A new divisor only lands where a half-period starts fresh.
            if ((!en || restart || toggle) && pend_valid) begin
                half_act   <= half_pend;
                pend_valid <= 1'b0;
            end
            if (!en || restart) begin
                cnt     <= '0;
                clk_div <= 1'b0;
                tick    <= 1'b0;
            end else if (toggle) begin
                cnt     <= '0;
                clk_div <= ~clk_div;
                tick    <= 1'b1;
            end else begin
                cnt  <= cnt + 1'b1;
                tick <= 1'b0;
            end
            // wr implies pend_valid was clear, so it never races a consumption.
            if (wr) begin
                half_pend  <= wr_half;
                pend_valid <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/clkdiv_multi.sv
// rtl/clkdiv_multi.sv - NCH independent square-wave dividers; CLKDIV_SYNC_EN adds sync port
module clkdiv_multi
    import clkdiv_pkg::*;
#(
    parameter int    NCH          = 4,
    parameter int    CW           = CLKDIV_CW,
    parameter half_t DEFAULT_HALF = half_t'(DEFAULT_HALF_C)
) (
    input  logic           Clk_O,
    input  logic           Clear,
`ifdef CLKDIV_SYNC_EN
    input  logic           sync,
`endif
    input  logic [NCH-1:0] en,
    clkdiv_multi_if.slave  cfg,
    output logic [NCH-1:0] Clk,
    output logic [NCH-1:0] tick
);
    localparam int CHW = ch_width(NCH);

    logic [NCH-1:0]        pend_valid;
    logic [(1<<CHW)-1:0]   pend_pad;
    logic                  accept;

    // Unused channel slots read as empty, so out-of-range writes are accepted and dropped.
    always_comb begin
        pend_pad          = '0;
        pend_pad[NCH-1:0] = pend_valid;
    end

    assign cfg.cfg_ready = ~pend_pad[cfg.cfg_ch];
    assign accept        = cfg.cfg_valid & cfg.cfg_ready;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        clkdiv_ch #(
            .CW          (CW),
            .DEFAULT_HALF(CW'(DEFAULT_HALF))
        ) u_ch (
            .clk       (Clk_O),
            .clear     (Clear),
`ifdef CLKDIV_SYNC_EN
            .sync      (sync),
`endif
            .en        (en[i]),
            .wr        (accept && (cfg.cfg_ch == CHW'(i))),
            .wr_half   (cfg.cfg_half),
            .clk_div   (Clk[i]),
            .tick      (tick[i]),
            .pend_valid(pend_valid[i])
        );
    end

endmodule

// File: tb/tb_clkdiv_multi.sv
// tb/tb_clkdiv_multi.sv - directed vector bench for clkdiv_multi (NCH=4/5, CW=8, DEFAULT_HALF=3)
module tb_clkdiv_multi;

    logic       Clk_O = 1'b0;
    logic       Clear;
    logic [3:0] en;
    logic [3:0] Clk;
    logic [3:0] tick;
    logic [4:0] en5;
    logic [4:0] clk5;
    logic [4:0] tick5;
`ifdef CLKDIV_SYNC_EN
    logic       sync;
`endif

    int n_run  = 0;
    int n_fail = 0;

    clkdiv_multi_if #(.NCH(4), .CW(8)) cfg_bus ();
    clkdiv_multi_if #(.NCH(5), .CW(8)) cfg5 ();

    clkdiv_multi #(.NCH(4), .CW(8), .DEFAULT_HALF(3)) dut (
        .Clk_O(Clk_O),
        .Clear(Clear),
`ifdef CLKDIV_SYNC_EN
        .sync (sync),
`endif
        .en   (en),
        .cfg  (cfg_bus),
        .Clk  (Clk),
        .tick (tick)
    );

    clkdiv_multi #(.NCH(5), .CW(8), .DEFAULT_HALF(3)) dut5 (
        .Clk_O(Clk_O),
        .Clear(Clear),
`ifdef CLKDIV_SYNC_EN
        .sync (sync),
`endif
        .en   (en5),
        .cfg  (cfg5),
        .Clk  (clk5),
        .tick (tick5)
    );

    always #5 Clk_O = ~Clk_O;

    typedef struct {
        logic       clr;
        logic [3:0] en;
        logic       v;
        logic [1:0] ch;
        logic [7:0] half;
        logic       rdy;
        logic [3:0] exp_clk;
        logic [3:0] exp_tick;
    } row_t;

    row_t rows[$];

    function automatic void add(input logic clr, input logic [3:0] e, input logic v,
                                input logic [1:0] ch, input logic [7:0] half, input logic rdy,
                                input logic [3:0] c, input logic [3:0] t);
        row_t r;
        r.clr = clr; r.en = e; r.v = v; r.ch = ch; r.half = half;
        r.rdy = rdy; r.exp_clk = c; r.exp_tick = t;
        rows.push_back(r);
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    initial begin
        logic [8:0] pat;
        pat = 9'b001111000;

        // ch0 free-running from reset: rise after 4 edges, period 8
        add(1, 4'b0001, 0, 0, 0, 1, 4'b0000, 4'b0000);
        add(0, 4'b0001, 0, 0, 0, 1, 4'b0000, 4'b0000);
        add(0, 4'b0001, 0, 0, 0, 1, 4'b0000, 4'b0000);
        add(0, 4'b0001, 0, 0, 0, 1, 4'b0001, 4'b0001);
        add(0, 4'b0001, 0, 0, 0, 1, 4'b0001, 4'b0000);
        add(0, 4'b0001, 0, 0, 0, 1, 4'b0001, 4'b0000);
        add(0, 4'b0001, 0, 0, 0, 1, 4'b0001, 4'b0000);
        add(0, 4'b0001, 0, 0, 0, 1, 4'b0000, 4'b0001);
        add(0, 4'b0001, 0, 0, 0, 1, 4'b0000, 4'b0000);
        // ch1 half=0 written mid-count
        add(1, 4'b0010, 0, 1, 0, 1, 4'b0000, 4'b0000);
        add(0, 4'b0010, 0, 1, 0, 1, 4'b0000, 4'b0000);
        add(0, 4'b0010, 1, 1, 0, 1, 4'b0000, 4'b0000);
        add(0, 4'b0010, 0, 1, 0, 0, 4'b0010, 4'b0010);
        add(0, 4'b0010, 0, 1, 0, 1, 4'b0000, 4'b0010);
        add(0, 4'b0010, 0, 1, 0, 1, 4'b0010, 4'b0010);
        add(0, 4'b0010, 0, 1, 0, 1, 4'b0000, 4'b0010);
        // ch2 back-to-back writes 5 then 1
        add(1, 4'b0100, 1, 2, 5, 1, 4'b0000, 4'b0000);
        add(0, 4'b0100, 1, 2, 1, 0, 4'b0000, 4'b0000);
        add(0, 4'b0100, 1, 2, 1, 0, 4'b0000, 4'b0000);
        add(0, 4'b0100, 1, 2, 1, 0, 4'b0100, 4'b0100);
        add(0, 4'b0100, 1, 2, 1, 1, 4'b0100, 4'b0000);
        add(0, 4'b0100, 0, 2, 0, 0, 4'b0100, 4'b0000);
        add(0, 4'b0100, 0, 2, 0, 0, 4'b0100, 4'b0000);
        add(0, 4'b0100, 0, 2, 0, 0, 4'b0100, 4'b0000);
        add(0, 4'b0100, 0, 2, 0, 0, 4'b0100, 4'b0000);
        add(0, 4'b0100, 0, 2, 0, 0, 4'b0000, 4'b0100);
        add(0, 4'b0100, 0, 2, 0, 1, 4'b0000, 4'b0000);
        add(0, 4'b0100, 0, 2, 0, 1, 4'b0100, 4'b0100);
        add(0, 4'b0100, 0, 2, 0, 1, 4'b0100, 4'b0000);
        add(0, 4'b0100, 0, 2, 0, 1, 4'b0000, 4'b0100);

        Clear = 1'b1;
        en = '0; en5 = '0;
        cfg_bus.cfg_valid = 1'b0; cfg_bus.cfg_ch = '0; cfg_bus.cfg_half = '0;
        cfg5.cfg_valid = 1'b0; cfg5.cfg_ch = '0; cfg5.cfg_half = '0;
`ifdef CLKDIV_SYNC_EN
        sync = 1'b0;
`endif
        #2;
        chk("reset_clk", 0, Clk, 4'b0000);
        chk("reset_tick", 0, tick, 4'b0000);
        chk("reset_ready", 0, cfg_bus.cfg_ready, 1'b1);
        @(posedge Clk_O); #1;
        Clear = 1'b0;

        for (int i = 0; i < rows.size(); i++) begin
            if (rows[i].clr) begin
                Clear = 1'b1; #1; Clear = 1'b0;
            end
            en = rows[i].en;
            cfg_bus.cfg_valid = rows[i].v;
            cfg_bus.cfg_ch    = rows[i].ch;
            cfg_bus.cfg_half  = rows[i].half;
            #1;
            chk("row_ready", i, cfg_bus.cfg_ready, rows[i].rdy);
            @(posedge Clk_O); #1;
            chk("row_clk", i, Clk, rows[i].exp_clk);
            chk("row_tick", i, tick, rows[i].exp_tick);
        end

        // Clear mid-count with a pending write outstanding
        cfg_bus.cfg_valid = 1'b0;
        Clear = 1'b1; #1; Clear = 1'b0;
        en = 4'b0001;
        repeat (5) @(posedge Clk_O);
        #1;
        cfg_bus.cfg_valid = 1'b1; cfg_bus.cfg_ch = 0; cfg_bus.cfg_half = 0;
        @(posedge Clk_O); #1;
        cfg_bus.cfg_valid = 1'b0;
        chk("midclr_pend_ready", 0, cfg_bus.cfg_ready, 1'b0);
        chk("midclr_clk_before", 0, Clk, 4'b0001);
        Clear = 1'b1; #1;
        chk("midclr_clk_async", 0, Clk, 4'b0000);
        chk("midclr_tick_async", 0, tick, 4'b0000);
        chk("midclr_ready_held", 0, cfg_bus.cfg_ready, 1'b1);
        @(posedge Clk_O); #1;
        Clear = 1'b0;
        for (int k = 0; k < 9; k++) begin
            @(posedge Clk_O); #1;
            chk("midclr_period", k, Clk[0], pat[k]);
        end

        // disable forces the output low, re-enable restarts from cnt=0
        repeat (3) @(posedge Clk_O);
        #1;
        chk("pre_disable_clk", 0, Clk[0], 1'b1);
        en = 4'b0000;
        @(posedge Clk_O); #1;
        chk("disable_clk", 0, Clk, 4'b0000);
        chk("disable_tick", 0, tick, 4'b0000);
        en = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            @(posedge Clk_O); #1;
            chk("reenable_clk", k, Clk[0], (k == 3));
            chk("reenable_tick", k, tick[0], (k == 3));
        end

        // out-of-range channel write on a 5-channel instance
        en = 4'b0000;
        Clear = 1'b1; #1; Clear = 1'b0;
        en5 = 5'b00001;
        cfg5.cfg_valid = 1'b1; cfg5.cfg_ch = 3'd5; cfg5.cfg_half = 8'd9;
        #1;
        chk("oor_ready", 0, cfg5.cfg_ready, 1'b1);
        for (int k = 0; k < 9; k++) begin
            @(posedge Clk_O); #1;
            chk("oor_period", k, clk5[0], pat[k]);
            chk("oor_ready_hold", k, cfg5.cfg_ready, 1'b1);
        end
        cfg5.cfg_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            cfg5.cfg_ch = 3'(c);
            #1;
            chk("oor_no_pending", c, cfg5.cfg_ready, 1'b1);
        end
        en5 = '0;

`ifdef CLKDIV_SYNC_EN
        @(posedge Clk_O); #1;
        Clear = 1'b1; #1; Clear = 1'b0;
        en = 4'b0001;
        repeat (2) @(posedge Clk_O);
        #1;
        en = 4'b1001;
        repeat (2) @(posedge Clk_O);
        #1;
        chk("sync_out_of_phase", 0, Clk, 4'b0001);
        sync = 1'b1;
        @(posedge Clk_O); #1;
        sync = 1'b0;
        chk("sync_clk", 0, Clk, 4'b0000);
        chk("sync_tick", 0, tick, 4'b0000);
        for (int k = 0; k < 4; k++) begin
            @(posedge Clk_O); #1;
            chk("sync_align_clk", k, Clk, (k == 3) ? 4'b1001 : 4'b0000);
            chk("sync_align_tick", k, tick, (k == 3) ? 4'b1001 : 4'b0000);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/clkdiv_multi.md
CLKDIV_MULTI -- requirements
Module: clkdiv_multi

Interface
REQ-001 SHALL have parameter NCH, default 4: number of independent divider channels (1..16).
REQ-002 SHALL have parameter CW, default 25: half-period counter and divisor width.
REQ-003 SHALL have parameter DEFAULT_HALF, default 24999999: half-period divisor loaded into every channel at reset.
REQ-004 SHALL use one clock and an asynchronous, active-high reset, ports named Clk_O and Clear.
REQ-005 Clk_O  input  1  sole clock; all state updates on rising edge.
REQ-006 Clear  input  1  asynchronous active-high reset.
REQ-007 en  input  NCH  per-channel run enable.
REQ-008 cfg_valid  input  1  divisor write request.
REQ-009 cfg_ch  input  max(1,clog2(NCH))  target channel index.
REQ-010 cfg_half  input  CW  new half-period divisor.
REQ-011 cfg_ready  output  1  write accept; transfer occurs when cfg_valid && cfg_ready at a rising edge.
REQ-012 Clk  output  NCH  divided square-wave outputs, registered.
REQ-013 tick  output  NCH  one-cycle pulse on every toggle of the matching Clk bit.

Function
REQ-014 Per channel state SHALL be: cnt (CW bits), half_act (CW), half_pend (CW), pend_valid (1), Clk bit, tick bit.
REQ-015 Enabled channel, cnt >= half_act: cnt<=0, Clk toggles, tick<=1; else cnt<=cnt+1, tick<=0.
REQ-016 Output period SHALL be 2*(half_act+1) Clk_O cycles; half_act=0 gives Clk_O/2; counter never wraps.
REQ-017 cfg_ready SHALL be combinational ~pend_valid[cfg_ch]; accepted write sets half_pend and pend_valid of that channel.
REQ-018 Pending divisor SHALL be applied only at a toggle edge (half_act<=half_pend, pend_valid<=0), so no half-period is ever truncated or glitched.
REQ-019 Write to a channel whose pend_valid is being consumed in the same cycle SHALL NOT be accepted (ready reflects registered pend_valid).
REQ-020 cfg_ch >= NCH SHALL be accepted (cfg_ready=1) and discarded with no state change.
REQ-021 Disabled channel: cnt<=0, Clk<=0, tick<=0 on next edge; pending divisor applied immediately.
REQ-022 Re-enable SHALL start counting from cnt=0, Clk=0; first rising Clk after half_act+1 enabled cycles.
REQ-023 Channels SHALL be fully independent; simultaneous toggles on several channels permitted.

Reset
REQ-024 Clear=1 SHALL immediately, without a clock edge, force cnt=0, Clk=0, tick=0, pend_valid=0, half_act=DEFAULT_HALF on all channels.
REQ-025 Clear asserted mid-count SHALL discard pending writes; cfg_ready=1 while Clear is held.

Configuration
REQ-026 Macro CLKDIV_SYNC_EN, when defined, SHALL add input port sync (1 bit).
REQ-027 With CLKDIV_SYNC_EN: sync=1 at an edge forces cnt<=0, Clk<=0, tick<=0 and applies any pending divisor on all enabled channels, priority over REQ-015.
REQ-028 Without CLKDIV_SYNC_EN: no sync port, no phase-alignment logic; all other behaviour identical.

Structure
REQ-029 Package clkdiv_pkg SHALL hold CW default, DEFAULT_HALF constant and typedef half_t (CW-bit divisor).
REQ-030 Sub-module clkdiv_ch SHALL implement one channel (REQ-014..022), instantiated NCH times via generate.

Verification (NCH=4, CW=8, DEFAULT_HALF=3)
REQ-031 Clear, then en=0001 -> Clk[0] rises 4 cycles after enable, period 8 cycles; tick[0] every 4 cycles; Clk[3:1]=0.
REQ-032 Ch1 running half=3, write half=0 mid-count -> current half-period completes at 4 cycles, then Clk[1] toggles every cycle.
REQ-033 Two back-to-back writes to ch2 (5 then 1) -> second held with cfg_ready=0 until toggle edge consumes 5; 1 applied at the following toggle.
REQ-034 Clear asserted at cnt=2, Clk[0]=1 -> all Clk and tick 0 before next Clk_O edge; after release period again 8 cycles.
REQ-035 cfg_ch=5, cfg_half=9, cfg_valid=1 -> cfg_ready=1, no channel period change.
REQ-036 CLKDIV_SYNC_EN defined, ch0 and ch3 running out of phase, sync pulse -> both Clk rise together 4 cycles later.
